// File: rtl/rx_timer_ctrl.sv
// Serial receive bit-timing / frame-sequencing controller driving a bit-period timer and a bit counter.
// Optional RX_FRAMING_ERR_EN enables the registered framing_error flag (otherwise tied low).

module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);
    // clear together with count_enable restarts the count at 1 so the first
    // cycle of a new state/bit period already reads as count 1
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            count_out <= '0;
        else if (clear)
            count_out <= count_enable ? NUM_CNT_BITS'(1) : '0;
        else if (count_enable)
            count_out <= (count_out == rollover_val) ? NUM_CNT_BITS'(1)
                                                     : count_out + NUM_CNT_BITS'(1);
    end
endmodule

module rx_timer_ctrl #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic start_detect,
    input  logic serial_in,
    input  logic abort,
    output logic busy,
    output logic shift_strobe,
    output logic packet_done,
    output logic stop_bit,
    output logic framing_error
);
    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_HALF = TW'(H);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_ROLL = BW'(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
    state_t state;

    logic [TW-1:0] timer, t_roll;
    logic [BW-1:0] bit_cnt;
    logic t_clr, t_en, b_clr, b_en;
    logic timer_full, timer_half, last_bit;

    assign timer_full = (timer == T_FULL);
    assign timer_half = (timer == T_HALF);
    assign last_bit   = (bit_cnt == B_LAST);

    flex_counter #(.NUM_CNT_BITS(TW)) u_timer (
        .clk(clk), .n_rst(n_rst), .clear(t_clr), .count_enable(t_en),
        .rollover_val(t_roll), .count_out(timer)
    );

    flex_counter #(.NUM_CNT_BITS(BW)) u_bits (
        .clk(clk), .n_rst(n_rst), .clear(b_clr), .count_enable(b_en),
        .rollover_val(B_ROLL), .count_out(bit_cnt)
    );

    always_comb begin
        t_clr  = 1'b0;
        t_en   = 1'b0;
        b_clr  = 1'b0;
        b_en   = 1'b0;
        t_roll = T_FULL;
        if (abort) begin
            t_clr = 1'b1;
            b_clr = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    t_clr = 1'b1;
                    t_en  = start_detect;
                    b_clr = 1'b1;
                end
                START: begin
                    t_roll = T_HALF;
                    b_clr  = 1'b1;
                    if (timer_half) begin
                        t_clr = 1'b1;
                        t_en  = ~serial_in;
                    end else begin
                        t_en = 1'b1;
                    end
                end
                DATA: begin
                    t_en  = 1'b1;
                    t_clr = timer_full && last_bit;
                    b_clr = timer_full && last_bit;
                    b_en  = timer_full && !last_bit;
                end
                STOP: begin
                    b_clr = 1'b1;
                    t_clr = timer_full;
                    t_en  = !timer_full;
                end
                default: begin
                    t_clr = 1'b1;
                    b_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            stop_bit <= 1'b1;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:  if (start_detect) state <= START;
                START: if (timer_half) state <= serial_in ? IDLE : DATA;
                DATA:  if (timer_full && last_bit) state <= STOP;
                STOP: begin
                    if (timer_full) begin
                        stop_bit <= serial_in;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RX_FRAMING_ERR_EN
    // flag persists across frames until the next accepted start
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            framing_error <= 1'b0;
        else if (!abort) begin
            if (state == IDLE && start_detect)
                framing_error <= 1'b0;
            else if (state == STOP && timer_full)
                framing_error <= ~serial_in;
        end
    end
`else
    assign framing_error = 1'b0;
`endif

    assign busy         = (state != IDLE);
    assign shift_strobe = (state == DATA) && timer_full;
    assign packet_done  = (state == DONE);
endmodule

// File: tb/tb_rx_timer_ctrl.sv
// Self-checking bench for rx_timer_ctrl: default (10/8) and edge (4/1) instances,
// randomized frame content checked against a cycle-number timing model.

module tb_rx_timer_ctrl;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic sd0 = 1'b0, si0 = 1'b1, ab0 = 1'b0;
    logic sd1 = 1'b0, si1 = 1'b1, ab1 = 1'b0;
    logic busy0, str0, done0, stop0, fe0;
    logic busy1, str1, done1, stop1, fe1;

    int checks = 0;
    int errors = 0;
    logic exp_stop [2];
    logic exp_fe   [2];

    always #5 clk = ~clk;

    rx_timer_ctrl u0 (
        .clk(clk), .n_rst(n_rst), .start_detect(sd0), .serial_in(si0), .abort(ab0),
        .busy(busy0), .shift_strobe(str0), .packet_done(done0),
        .stop_bit(stop0), .framing_error(fe0)
    );

    rx_timer_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(1)) u1 (
        .clk(clk), .n_rst(n_rst), .start_detect(sd1), .serial_in(si1), .abort(ab1),
        .busy(busy1), .shift_strobe(str1), .packet_done(done1),
        .stop_bit(stop1), .framing_error(fe1)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_in(input int sel, input logic sd, input logic si, input logic ab);
        if (sel == 0) begin sd0 = sd; si0 = si; ab0 = ab; end
        else          begin sd1 = sd; si1 = si; ab1 = ab; end
    endtask

    task automatic check_outs(input int sel, input string ctx,
                              input logic eb, input logic es, input logic ed);
        logic b, s, d, sb, fe;
        b  = sel ? busy1 : busy0;
        s  = sel ? str1  : str0;
        d  = sel ? done1 : done0;
        sb = sel ? stop1 : stop0;
        fe = sel ? fe1   : fe0;
        chk({ctx, " busy"}, b, eb);
        chk({ctx, " shift_strobe"}, s, es);
        chk({ctx, " packet_done"}, d, ed);
        chk({ctx, " stop_bit"}, sb, exp_stop[sel]);
        chk({ctx, " framing_error"}, fe, exp_fe[sel]);
    endtask

    task automatic idle(input int sel, input int n, input string name);
        set_in(sel, 1'b0, 1'b1, 1'b0);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            check_outs(sel, $sformatf("%s/dut%0d/c%0d", name, sel, t), 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
        end
    endtask

    // Cycle 0 = start_detect sampled in IDLE; expectations follow from H, C, D arithmetic.
    task automatic run_frame(input int sel, input int c, input int d, input bit fs,
                             input bit stop_val, input int abort_at, input int reset_at,
                             input bit inject, input int ncyc, input string name);
        int h, endt, data_end;
        logic [31:0] data;
        logic sd, si, ab, eb, es, ed;
        bit killed;
        h = c / 2;
        data_end = h + c * d;
        endt = fs ? h : data_end + c + 1;
        data = $urandom;
        for (int t = 0; t < ncyc; t++) begin
            sd = (t == 0);
            if (inject && t >= 1 && t <= endt && (abort_at < 0 || t < abort_at)
                && (t % 7 == 3 || t == endt))
                sd = 1'b1;
            if (t >= 1 && t <= h)                       si = (fs && t == h) ? 1'b1 : 1'b0;
            else if (!fs && t > h && t <= data_end)     si = data[(t - h - 1) / c];
            else if (!fs && t > data_end && t < endt)   si = stop_val;
            else                                        si = 1'b1;
            ab = (t == abort_at);
            if (t == reset_at) n_rst = 1'b0;
            set_in(sel, sd, si, ab);

            killed = (abort_at >= 0 && t > abort_at) || (reset_at >= 0 && t >= reset_at);
            if (reset_at >= 0 && t == reset_at) begin
                exp_stop[0] = 1'b1; exp_stop[1] = 1'b1;
                exp_fe[0]   = 1'b0; exp_fe[1]   = 1'b0;
            end
            if (!killed && t == 1) exp_fe[sel] = 1'b0;
            if (!killed && !fs && t == endt) begin
                exp_stop[sel] = stop_val;
`ifdef RX_FRAMING_ERR_EN
                exp_fe[sel] = ~stop_val;
`endif
            end
            eb = !killed && t >= 1 && t <= endt;
            es = !killed && !fs && t > h && t <= data_end && ((t - h) % c == 0) && t != abort_at;
            ed = !killed && !fs && t == endt && t != abort_at;

            @(negedge clk);
            check_outs(sel, $sformatf("%s/dut%0d/c%0d", name, sel, t), eb, es, ed);
            @(posedge clk); #1;
        end
        n_rst = 1'b1;
        set_in(sel, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int a;
        exp_stop[0] = 1'b1; exp_stop[1] = 1'b1;
        exp_fe[0]   = 1'b0; exp_fe[1]   = 1'b0;

        #12;
        check_outs(0, "reset/dut0", 1'b0, 1'b0, 1'b0);
        check_outs(1, "reset/dut1", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        idle(0, 20, "quiet");

        run_frame(0, 10, 8, 1'b0, 1'b1, -1, -1, 1'b1, 97, "good");
        run_frame(0, 10, 8, 1'b1, 1'b1, -1, -1, 1'b0, 8, "false_start");
        run_frame(0, 10, 8, 1'b0, 1'b0, -1, -1, 1'b0, 97, "bad_stop");
        idle(0, 5, "bad_stop_hold");
        run_frame(0, 10, 8, 1'b0, 1'b1, 40, -1, 1'b1, 110, "abort40");
        run_frame(0, 10, 8, 1'b0, 1'($urandom % 2), -1, -1, 1'b1, 97, "after_abort");

        a = 6 + int'($urandom % 80);
        if ((a - 5) % 10 == 0) a++;
        run_frame(0, 10, 8, 1'b0, 1'b1, a, -1, 1'b1, 100, "abort_rand");

        run_frame(0, 10, 8, 1'b0, 1'b0, -1, -1, 1'b0, 97, "pre_reset");
        run_frame(0, 10, 8, 1'b0, 1'b1, -1, 50, 1'b0, 60, "reset50");
        idle(0, 20, "post_reset");

        run_frame(1, 4, 1, 1'b0, 1'b1, -1, -1, 1'b1, 12, "edge_good");
        run_frame(1, 4, 1, 1'b0, 1'b0, -1, -1, 1'b1, 12, "edge_bad");
        run_frame(1, 4, 1, 1'b1, 1'b1, -1, -1, 1'b0, 3, "edge_false");
        idle(1, 5, "edge_idle");

        for (int i = 0; i < 3; i++)
            run_frame(0, 10, 8, 1'b0, 1'($urandom % 2), -1, -1, 1'b1, 97, $sformatf("rand%0d", i));
        idle(0, 5, "tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
